clk_div_n: RTL

- Runtime-programmable integer clock divider, N from 2 to 2^CNT_W-1.
- 50% duty cycle for both even and odd N; odd N uses a posedge/negedge flop pair.
- Successor to the fixed divide-by-3 blocks in the divider collection; adds a programmable ratio, an enable, glitch-free ratio change at period boundaries, and a period-start tick.
- Feeds low-rate strobes and clocks to peripheral logic.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_cfg.sv | 55 +++++
 rtl/clk_div_n.sv | 73 +++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the programmable divider.
// Holds the default counter width, the minimum legal ratio and half_up().
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  // 32-bit so that n = 2^CNT_W-1 does not wrap to zero on the +1.
  function automatic logic [31:0] half_up(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// clk_div_cfg: ratio request validation, pending ratio and boundary apply.
// In: clk, rst, en, wrap, load, div_n. Out: cur_n, odd_q, cfg_err.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wrap,
  input  logic             load,
  input  logic [CNT_W-1:0] div_n,
  output logic [CNT_W-1:0] cur_n,
  output logic             odd_q,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DIV_DEFAULT);

  logic             pend;
  logic [CNT_W-1:0] pend_n;
  logic             load_ok;
  logic             apply;

  assign load_ok = load && (div_n >= CNT_W'(MIN_DIV));

  // Disabled divider has no period to protect, so apply at once.
  assign apply = pend && (wrap || !en);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= 1'b0;
      pend_n  <= DEF_N;
      cur_n   <= DEF_N;
      odd_q   <= DEF_N[0];
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= load && !load_ok;
      // Apply uses the old pend_n; a coincident load waits a period.
      if (apply) begin
        cur_n <= pend_n;
        odd_q <= pend_n[0];
      end
      if (load_ok) begin
        pend   <= 1'b1;
        pend_n <= div_n;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_n.sv
// clk_div_n: runtime-programmable 50% duty clock divider with period tick.
// In: clk, rst, en, div_n, load. Out: clk_out, tick, cur_n, cfg_err.
module clk_div_n
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] div_n,
  input  logic             load,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_n,
  output logic             cfg_err
);

  if (DIV_DEFAULT < MIN_DIV ||
      DIV_DEFAULT > (2 ** CNT_W) - 1) begin : g_bad_default
    $error("clk_div_n: DIV_DEFAULT out of range");
  end

  logic [CNT_W-1:0] ph;
  logic [CNT_W-1:0] half_n;
  logic             wrap;
  logic             odd_q;
  logic             clk_p;
  logic             clk_n;

  assign half_n = CNT_W'(half_up(32'(cur_n)));
  assign wrap   = en && (ph == cur_n - CNT_W'(1));

  clk_div_cfg #(
    .CNT_W       (CNT_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_cfg (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wrap    (wrap),
    .load    (load),
    .div_n   (div_n),
    .cur_n   (cur_n),
    .odd_q   (odd_q),
    .cfg_err (cfg_err)
  );

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      ph    <= '0;
      clk_p <= 1'b0;
      tick  <= 1'b0;
    end else begin
      ph    <= wrap ? '0 : ph + CNT_W'(1);
      clk_p <= ph < half_n;
      tick  <= ph == '0;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      clk_n <= 1'b0;
    end else begin
      clk_n <= clk_p;
    end
  end

  // Odd N: AND with the half-cycle-late copy trims half a cycle off high.
  assign clk_out = odd_q ? (clk_p & clk_n) : clk_p;

endmodule
